// File: rtl/shift_register_8bit_v2_pkg.sv
// Shared constants for the serial-in / parallel-out shift register.
//   DEFAULT_WIDTH : number of register stages when the top is not overridden
//   RESET_VALUE   : contents of all stages while reset is asserted
package shift_register_8bit_v2_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam logic [DEFAULT_WIDTH-1:0] RESET_VALUE = '0;

endpackage : shift_register_8bit_v2_pkg

// File: rtl/shift_register_8bit_v2_dff.sv
// Single-bit rising-edge D flip-flop with asynchronous active-low clear.
// Ports:
//   d     : data input, sampled on the rising edge of clk
//   clk   : clock
//   rst   : asynchronous active-low clear (0 forces q=0, q_bar=1)
//   q     : registered data
//   q_bar : complement of q
module dff_arst_n (
    input  logic d,
    input  logic clk,
    input  logic rst,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign q_bar = ~q;

endmodule : dff_arst_n

// File: rtl/shift_register_8bit_v2.sv
// Serial-in, parallel-out shift register built from a chain of D flip-flops.
// New bits enter at the MSB stage and move one stage toward the LSB on every
// rising clock edge; the LSB stage feeds the serial output.
// Ports:
//   clk  : rising-edge clock for all stages
//   rst  : asynchronous active-low reset, clears every stage to 0
//   sIn  : serial data in (enters stage WIDTH-1)
//   Q    : parallel view of all stages, Q[WIDTH-1] newest, Q[0] oldest
//   sOut : serial data out, always equal to Q[0]
module shift_register_8bit_v2
    import shift_register_8bit_v2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sIn,
    output logic [WIDTH-1:0] Q,
    output logic             sOut
);

    // chain[k] is the output of stage k; chain[WIDTH] is the serial input,
    // so stage k always loads chain[k+1].
    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] qBarUnused;

    assign chain[WIDTH] = sIn;

    for (genvar k = 0; k < WIDTH; k++) begin : gStage
        dff_arst_n uCell (
            .d     (chain[k+1]),
            .clk   (clk),
            .rst   (rst),
            .q     (chain[k]),
            .q_bar (qBarUnused[k])
        );
    end

    assign Q    = chain[WIDTH-1:0];
    assign sOut = chain[0];

endmodule : shift_register_8bit_v2

// File: tb/tb_shift_register_8bit_v2.sv
module tb_shift_register_8bit_v2;

    logic       clk;
    logic       rst;
    logic       sIn;
    logic [7:0] Q;
    logic       sOut;

    int tests;
    int fails;

    // Expected register contents after each rising edge, oldest first.
    logic [7:0] expQ[$];
    // Reference model: the register contents as a plain byte.
    logic [7:0] model;

    shift_register_8bit_v2 #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .sIn  (sIn),
        .Q    (Q),
        .sOut (sOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: after every rising edge compare against the oldest expectation.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("edge_Q", Q, e);
            check("edge_sOut", {7'b0, sOut}, {7'b0, e[0]});
        end
    end

    // Drive one bit from a falling edge, let one rising edge pass, and
    // record what the register must hold afterwards. Ends on a falling edge.
    task automatic step(input logic b);
        sIn = b;
        @(posedge clk);
        if (rst) model = (model >> 1) | ({7'b0, b} << 7);
        else     model = 8'h00;
        expQ.push_back(model);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pattern;
        logic       b;
        tests = 0;
        fails = 0;
        model = 8'h00;
        rst   = 1'b0;
        sIn   = 1'b0;

        // Power-up reset
        @(negedge clk);
        @(negedge clk);
        check("reset_Q", Q, 8'h00);
        check("reset_sOut", {7'b0, sOut}, 8'h00);
        rst = 1'b1;

        // All ones: 8 edges fill the register
        for (int i = 1; i <= 8; i++) begin
            step(1'b1);
            check("ones_sOut", {7'b0, sOut}, (i == 8) ? 8'h01 : 8'h00);
        end
        check("ones_Q", Q, 8'hFF);
        step(1'b1);
        check("ones_sOut_hold", {7'b0, sOut}, 8'h01);

        // Asynchronous reset between edges, with register preloaded to FF
        #2;
        rst = 1'b0;
        model = 8'h00;
        #1;
        check("async_Q", Q, 8'h00);
        check("async_sOut", {7'b0, sOut}, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1);
        check("held_reset_Q", Q, 8'h00);

        // Walking one
        rst = 1'b1;
        step(1'b1);
        check("walk_Q", Q, 8'h80);
        for (int i = 2; i <= 8; i++) begin
            step(1'b0);
            check("walk_Q", Q, 8'h80 >> (i - 1));
            check("walk_sOut", {7'b0, sOut}, (i == 8) ? 8'h01 : 8'h00);
        end
        step(1'b0);
        check("walk_out_Q", Q, 8'h00);

        // Fixed pattern 1,0,1,1,0,0,1,0 (first bit first)
        pattern = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) step(pattern[i]);
        check("pattern_Q", Q, 8'h4D);

        // Mid-stream reset discards in-flight bits
        for (int i = 0; i < 4; i++) step(1'b1);
        rst = 1'b0;
        model = 8'h00;
        #1;
        check("mid_async_Q", Q, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0);
        check("mid_release_Q", Q, 8'h00);

        // Random bits, each held for two edges
        for (int i = 0; i < 60; i++) begin
            b = 1'($urandom_range(0, 1));
            step(b);
            step(b);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", 8'(expQ.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_shift_register_8bit_v2

// File: doc/shift_register_8bit_v2.md
SHIFT_REGISTER_8BIT_V2 -- requirements
Module: shift_register_8bit_v2

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be asynchronous and active-low, with ports named clk and rst.
REQ-002 Parameter WIDTH, default 8: number of register stages; the SHALL-level behaviour below is stated for WIDTH=8.
REQ-003 clk  input  1  rising-edge clock for all stages.
REQ-004 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-005 sIn  input  1  serial data in, entering the MSB stage.
REQ-006 Q  output  WIDTH  parallel view of all stages; Q[7] is the newest bit and Q[0] the oldest.
REQ-007 sOut  output  1  serial data out; SHALL equal Q[0] combinationally at all times.

Function
REQ-008 On each clk rising edge with rst=1, Q[7] SHALL load sIn and Q[k] SHALL load Q[k+1] for k=6..0, all simultaneously (shift toward LSB).
REQ-009 Latency: a bit sampled on sIn SHALL appear on Q[7] after edge 1 and on sOut after edge 8.
REQ-010 Between edges, Q and sOut SHALL hold; sIn changes away from an edge SHALL have no effect.
REQ-011 The old Q[0] SHALL be discarded at each shift; there is no wrap-around or recirculation.
REQ-012 There is no enable or parallel load; every rising edge with rst=1 SHALL shift.
REQ-013 sIn value X/unknown SHALL propagate as stored data; no special handling.

Reset
REQ-014 When rst=0, all stages SHALL clear to 0 immediately, without waiting for clk; Q=8'h00 and sOut=0.
REQ-015 While rst=0, clk edges SHALL be ignored and Q SHALL stay 8'h00.
REQ-016 Reset asserted mid-stream SHALL discard all in-flight bits.
REQ-017 On release (rst 0->1), the first shift SHALL occur at the next rising edge, loading sIn into Q[7] with zeros below.
REQ-018 If rst rises coincident with a clk edge, that edge SHALL NOT shift; shifting SHALL resume on the following edge.

Structure
REQ-019 A shared package SHALL hold the default WIDTH (8) and the reset value constant (all zeros).
REQ-020 One sub-module SHALL be used: a single-bit D flip-flop, dff_arst_n (ports d, clk, rst, q, q_bar), rising-edge, with asynchronous active-low clear to q=0 and q_bar=1.
REQ-021 The top SHALL instantiate WIDTH dff_arst_n cells in a generate loop, chaining d of stage k to q of stage k+1 and d of stage WIDTH-1 to sIn; q_bar outputs SHALL be left unused at the top.
REQ-022 Q SHALL be driven directly from the cell q outputs, and sOut from stage 0, with no extra registering.

Verification
REQ-023 Reset: preload Q=8'hFF, drive rst=0 between edges -> Q=8'h00 and sOut=0 before the next clk edge, and Q stays 8'h00 over 3 edges.
REQ-024 Walking one: release reset, drive sIn=1 for one edge, then 0 -> Q=8'h80, 8'h40, ... 8'h01 on edges 1..8, and sOut=1 only after edge 8.
REQ-025 All ones: after reset, drive sIn=1 for 8 edges -> Q=8'hFF, and sOut=1 from edge 8 onward.
REQ-026 Pattern: shift in 1,0,1,1,0,0,1,0 (first bit first) -> Q=8'h4D after 8 edges.
REQ-027 Mid-stream reset: after 4 shifts of 1, assert rst for 3 cycles, then release with sIn=0 -> Q=8'h00 throughout and after release.
REQ-028 Random: 60 random sIn values, each held 2 clock cycles, compared against a behavioural 8-bit right-shift model -> Q and sOut match the model at every edge.
